// File: rtl/pattern_match_if.sv
// Bus bundle between a byte source / configuring agent and pattern_match_ctrl.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. The offering side holds its valid and payload stable until
// that edge. ready never depends on valid in the same cycle. This applies
// to cfg_valid/cfg_ready and to in_valid/in_ready.
interface pattern_match_if #(
  parameter int PW    = 5,
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PW-1:0]    cfg_pattern;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             abort;
  logic             clear;
  logic             hit;
  logic [CNT_W-1:0] hit_count;
  logic             done;
  logic             busy;

  modport master (
    output cfg_valid, cfg_pattern, cfg_overlap, cfg_target,
    output in_valid, in_data, abort, clear,
    input  cfg_ready, in_ready, hit, hit_count, done, busy
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_overlap, cfg_target,
    input  in_valid, in_data, abort, clear,
    output cfg_ready, in_ready, hit, hit_count, done, busy
  );
endinterface

// File: rtl/pattern_match_ctrl.sv
// Configurable serial pattern detector: takes a pattern/overlap/target
// configuration, serializes incoming bytes MSB first at one bit per clock,
// counts pattern matches and stops once the target count is reached.
module pattern_match_ctrl #(
  parameter int PW    = 5,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pattern_match_if.slave       bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int              LW      = $clog2(PW + 1);
  localparam logic [LW-1:0]   PW_L    = LW'(PW);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;

  logic [PW-1:0]    pattern_q;
  logic             overlap_q;
  logic [CNT_W-1:0] target_q;
  logic [7:0]       shreg;
  logic [3:0]       bits_left;
  logic [PW-1:0]    hist;
  logic [LW-1:0]    hist_len;
  logic [CNT_W-1:0] count;
  logic             hit_q;

  logic             in_rdy;
  logic             cfg_take;
  logic             shift_en;
  logic [PW-1:0]    hist_nxt;
  logic [LW-1:0]    len_nxt;
  logic             match;
  logic [CNT_W-1:0] count_nxt;
  logic             target_hit;
  logic             accept;

  // Ready only when the serializer is empty or emitting its last bit,
  // so consecutive bytes stream without a bubble.
  assign in_rdy = (state == S_RUN) && (bits_left <= 4'd1);

  // Datapath decode: the bit leaving the serializer this edge, the
  // history it produces and whether that completes a counted match.
  always_comb begin
    cfg_take   = (state == S_IDLE) && bus.cfg_valid;
    shift_en   = (state == S_RUN) && (bits_left != 4'd0) && !bus.abort;
    hist_nxt   = {hist[PW-2:0], shreg[7]};
    len_nxt    = (hist_len == PW_L) ? PW_L : hist_len + 1'b1;
    match      = shift_en && (len_nxt == PW_L) && (hist_nxt == pattern_q);
    count_nxt  = (count == CNT_MAX) ? count : count + 1'b1;
    target_hit = match && (target_q != '0) && (count_nxt == target_q);
    // A byte offered on the target edge is swallowed: DONE discards it.
    accept     = in_rdy && bus.in_valid && !bus.abort && !target_hit;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort outranks clear and the target transition.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cfg_take) state_nxt = S_RUN;
      S_RUN: begin
        if (bus.abort)      state_nxt = S_IDLE;
        else if (target_hit) state_nxt = S_DONE;
      end
      S_DONE: if (bus.abort || bus.clear) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Configuration latch, serializer, history and hit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pattern_q <= '0;
      overlap_q <= 1'b0;
      target_q  <= '0;
      shreg     <= '0;
      bits_left <= '0;
      hist      <= '0;
      hist_len  <= '0;
      count     <= '0;
      hit_q     <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_take) begin
            pattern_q <= bus.cfg_pattern;
            overlap_q <= bus.cfg_overlap;
            target_q  <= bus.cfg_target;
            shreg     <= '0;
            bits_left <= '0;
            hist      <= '0;
            hist_len  <= '0;
            count     <= '0;
          end
        end
        S_RUN: begin
          hit_q <= match;
          if (shift_en) begin
            shreg     <= {shreg[6:0], 1'b0};
            bits_left <= bits_left - 4'd1;
            hist      <= hist_nxt;
            // Non-overlap mode demands PW fresh bits after each match.
            hist_len  <= (match && !overlap_q) ? '0 : len_nxt;
            if (match) count <= count_nxt;
          end
          // Load wins over the last-bit decrement; target discards the rest.
          if (target_hit) begin
            bits_left <= '0;
          end else if (accept) begin
            shreg     <= bus.in_data;
            bits_left <= 4'd8;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cfg_ready = (state == S_IDLE);
  assign bus.in_ready  = in_rdy;
  assign bus.hit       = hit_q;
  assign bus.hit_count = count;
  assign bus.done      = (state == S_DONE);
  assign bus.busy      = (state == S_RUN);
  assign dbg_state     = state;

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// Bench for pattern_match_ctrl: a PW=5/CNT_W=8 instance driven by a bit-queue
// reference model, and a PW=8/CNT_W=2 instance for saturation.
module tb_pattern_match_ctrl;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_a;
  logic [1:0] dbg_b;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] stim_q[$];
  int         acc_q[$];

  pattern_match_if #(.PW(5), .CNT_W(8)) bus_a ();
  pattern_match_if #(.PW(8), .CNT_W(2)) bus_b ();

  pattern_match_ctrl #(.PW(5), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .dbg_state(dbg_a)
  );

  pattern_match_ctrl #(.PW(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .dbg_state(dbg_b)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus_a.cfg_valid = 0; bus_a.cfg_pattern = '0; bus_a.cfg_overlap = 0;
    bus_a.cfg_target = '0; bus_a.in_valid = 0; bus_a.in_data = '0;
    bus_a.abort = 0; bus_a.clear = 0;
    bus_b.cfg_valid = 0; bus_b.cfg_pattern = '0; bus_b.cfg_overlap = 0;
    bus_b.cfg_target = '0; bus_b.in_valid = 0; bus_b.in_data = '0;
    bus_b.abort = 0; bus_b.clear = 0;
  endtask

  task automatic abort_a();
    bus_a.abort = 1;
    @(posedge clk); #1;
    bus_a.abort = 0;
    vectors++;
    if (bus_a.cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_to_idle: cfg_ready=%b expected 1", bus_a.cfg_ready);
    end
  endtask

  // Configures dut_a, streams stim_q and checks every cycle against a
  // bit-queue model: pending bits of the current byte, a sliding window of
  // the last PW bits, and the saturating hit count.
  task automatic run_stream_a(input string name, input logic [4:0] pat,
                              input bit ovl, input logic [7:0] tgt,
                              input int gap_pct, input int abort_at,
                              output int hits_seen);
    bit pend[$];
    bit win[$];
    int cnt = 0;
    bit mdone = 0;
    bit exp_hit, exp_rdy, want, took, ab, b, finished;
    int idx = 0;
    int v;
    hits_seen = 0;
    finished = 0;
    acc_q.delete();

    vectors++;
    if (bus_a.cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s cfg_ready: got %b expected 1", name, bus_a.cfg_ready);
    end
    bus_a.cfg_valid = 1; bus_a.cfg_pattern = pat;
    bus_a.cfg_overlap = ovl; bus_a.cfg_target = tgt;
    @(posedge clk); #1;
    bus_a.cfg_valid = 0;
    vectors++;
    if (bus_a.busy !== 1'b1 || bus_a.in_ready !== 1'b1 || bus_a.hit_count !== 8'd0) begin
      miscompares++;
      $display("FAIL %s after_cfg: busy=%b in_ready=%b count=%0d expected 1 1 0",
               name, bus_a.busy, bus_a.in_ready, bus_a.hit_count);
    end

    for (int cyc = 0; cyc < 400; cyc++) begin
      exp_rdy = !mdone && (pend.size() <= 1);
      vectors++;
      if (bus_a.in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL %s in_ready cyc %0d: got %b expected %b", name, cyc, bus_a.in_ready, exp_rdy);
      end
      if (mdone || (idx >= stim_q.size() && pend.size() == 0 && abort_at < cyc)) begin
        finished = 1;
        break;
      end
      ab   = (cyc == abort_at);
      want = (idx < stim_q.size()) && ($urandom_range(0, 99) >= gap_pct);
      bus_a.in_valid = want;
      bus_a.in_data  = want ? stim_q[idx] : 8'($urandom);
      bus_a.abort    = ab;

      exp_hit = 0;
      took = want && exp_rdy;
      if (took) begin
        acc_q.push_back(cyc);
        idx++;
      end
      if (!ab) begin
        if (pend.size() > 0) begin
          b = pend.pop_front();
          win.push_back(b);
          if (win.size() > 5) void'(win.pop_front());
          v = 0;
          foreach (win[i]) v = v * 2 + int'(win[i]);
          if (win.size() == 5 && v == int'(pat)) begin
            exp_hit = 1;
            if (cnt < 255) cnt++;
            if (!ovl) win.delete();
            if (tgt != 0 && cnt == int'(tgt)) begin
              mdone = 1;
              pend.delete();
            end
          end
        end
        if (took && !mdone)
          for (int k = 7; k >= 0; k--) pend.push_back(stim_q[idx-1][k]);
      end

      @(posedge clk); #1;
      bus_a.abort = 0;
      bus_a.in_valid = 0;
      hits_seen += int'(bus_a.hit);
      vectors++;
      if (bus_a.hit !== exp_hit || bus_a.hit_count !== 8'(cnt) ||
          bus_a.done !== (mdone && !ab) || bus_a.busy !== (!mdone && !ab)) begin
        miscompares++;
        $display("FAIL %s outputs cyc %0d: hit=%b count=%0d done=%b busy=%b expected %b %0d %b %b",
                 name, cyc, bus_a.hit, bus_a.hit_count, bus_a.done, bus_a.busy,
                 exp_hit, cnt, mdone && !ab, !mdone && !ab);
      end
      if (ab) begin
        vectors++;
        if (bus_a.cfg_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL %s abort_idle: cfg_ready=%b expected 1", name, bus_a.cfg_ready);
        end
        finished = 1;
        break;
      end
    end
    if (!finished) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: stream did not finish within 400 cycles", name);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (bus_a.cfg_ready !== 1 || bus_a.in_ready !== 0 || bus_a.hit !== 0 ||
        bus_a.hit_count !== 8'd0 || bus_a.done !== 0 || bus_a.busy !== 0) begin
      miscompares++;
      $display("FAIL reset_a: rdy=%b in_rdy=%b hit=%b cnt=%0d done=%b busy=%b expected 1 0 0 0 0 0",
               bus_a.cfg_ready, bus_a.in_ready, bus_a.hit, bus_a.hit_count, bus_a.done, bus_a.busy);
    end
    vectors++;
    if (bus_b.cfg_ready !== 1 || bus_b.in_ready !== 0 || bus_b.hit !== 0 ||
        bus_b.hit_count !== 2'd0 || bus_b.done !== 0 || bus_b.busy !== 0) begin
      miscompares++;
      $display("FAIL reset_b: rdy=%b in_rdy=%b hit=%b cnt=%0d done=%b busy=%b expected 1 0 0 0 0 0",
               bus_b.cfg_ready, bus_b.in_ready, bus_b.hit, bus_b.hit_count, bus_b.done, bus_b.busy);
    end
  endtask

  task automatic test_overlap();
    int h;
    stim_q = '{8'hB6, 8'hC0};
    run_stream_a("overlap", 5'b10110, 1, 8'd0, 0, -1, h);
    vectors++;
    if (h !== 3 || bus_a.hit_count !== 8'd3) begin
      miscompares++;
      $display("FAIL overlap_total: hits=%0d count=%0d expected 3 3", h, bus_a.hit_count);
    end
    abort_a();
  endtask

  task automatic test_nonoverlap();
    int h;
    stim_q = '{8'hB6, 8'hC0};
    run_stream_a("nonoverlap", 5'b10110, 0, 8'd0, 0, -1, h);
    vectors++;
    if (h !== 2 || bus_a.hit_count !== 8'd2) begin
      miscompares++;
      $display("FAIL nonoverlap_total: hits=%0d count=%0d expected 2 2", h, bus_a.hit_count);
    end
    abort_a();
  endtask

  task automatic test_target();
    int h;
    stim_q = '{8'hB6, 8'hC0};
    run_stream_a("target", 5'b10110, 1, 8'd2, 0, -1, h);
    vectors++;
    if (h !== 2 || bus_a.hit_count !== 8'd2 || bus_a.in_ready !== 0 || bus_a.done !== 1) begin
      miscompares++;
      $display("FAIL target_done: hits=%0d count=%0d in_ready=%b done=%b expected 2 2 0 1",
               h, bus_a.hit_count, bus_a.in_ready, bus_a.done);
    end
    bus_a.clear = 1;
    @(posedge clk); #1;
    bus_a.clear = 0;
    vectors++;
    if (bus_a.cfg_ready !== 1 || bus_a.done !== 0 || bus_a.hit_count !== 8'd2) begin
      miscompares++;
      $display("FAIL target_clear: cfg_ready=%b done=%b count=%0d expected 1 0 2",
               bus_a.cfg_ready, bus_a.done, bus_a.hit_count);
    end
  endtask

  task automatic test_back_to_back();
    int h;
    stim_q.delete();
    for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom));
    run_stream_a("back_to_back", 5'($urandom), 1'($urandom), 8'd0, 0, -1, h);
    vectors++;
    if (acc_q.size() !== 4) begin
      miscompares++;
      $display("FAIL b2b_accepts: got %0d expected 4", acc_q.size());
    end
    for (int i = 0; i < acc_q.size(); i++) begin
      vectors++;
      if (acc_q[i] !== 8 * i) begin
        miscompares++;
        $display("FAIL b2b_spacing %0d: accepted at %0d expected %0d", i, acc_q[i], 8 * i);
      end
    end
    abort_a();
  endtask

  task automatic test_drain();
    int h;
    stim_q = '{8'h00};
    run_stream_a("drain", 5'b10110, 1, 8'd0, 0, -1, h);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus_a.hit !== 0 || bus_a.in_ready !== 1 || bus_a.busy !== 1) begin
        miscompares++;
        $display("FAIL drain_hold %0d: hit=%b in_ready=%b busy=%b expected 0 1 1",
                 i, bus_a.hit, bus_a.in_ready, bus_a.busy);
      end
    end
    abort_a();
  endtask

  task automatic test_abort_match();
    int h;
    stim_q = '{8'hB6, 8'hC0};
    run_stream_a("abort_match", 5'b10110, 1, 8'd0, 0, 5, h);
    vectors++;
    if (h !== 0 || bus_a.hit_count !== 8'd0) begin
      miscompares++;
      $display("FAIL abort_match_total: hits=%0d count=%0d expected 0 0", h, bus_a.hit_count);
    end
  endtask

  task automatic test_random();
    int h;
    for (int t = 0; t < 12; t++) begin
      stim_q.delete();
      for (int i = 0; i < 6; i++) stim_q.push_back(8'($urandom));
      run_stream_a("random", 5'($urandom), 1'($urandom), 8'($urandom_range(0, 4)),
                   30, (t % 4 == 3) ? int'($urandom_range(3, 40)) : -1, h);
      if (bus_a.done === 1'b1) begin
        bus_a.clear = 1;
        @(posedge clk); #1;
        bus_a.clear = 0;
      end else if (bus_a.cfg_ready !== 1'b1) begin
        abort_a();
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bus_a.cfg_valid = 1; bus_a.cfg_pattern = 5'b10110;
    bus_a.cfg_overlap = 1; bus_a.cfg_target = 8'd0;
    @(posedge clk); #1;
    bus_a.cfg_valid = 0;
    bus_a.in_valid = 1; bus_a.in_data = 8'hB6;
    repeat (7) @(posedge clk);
    #1;
    bus_a.in_valid = 0;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    vectors++;
    if (bus_a.cfg_ready !== 1 || bus_a.in_ready !== 0 || bus_a.hit !== 0 ||
        bus_a.hit_count !== 8'd0 || bus_a.done !== 0 || bus_a.busy !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_run: rdy=%b in_rdy=%b hit=%b cnt=%0d done=%b busy=%b expected 1 0 0 0 0 0",
               bus_a.cfg_ready, bus_a.in_ready, bus_a.hit, bus_a.hit_count, bus_a.done, bus_a.busy);
    end
  endtask

  // PW=8, CNT_W=2: all-ones pattern over all-ones bytes hits on every bit
  // from the 8th; the count pins at 3; a second configuration is ignored.
  task automatic test_saturate();
    int exp_cnt;
    bus_b.cfg_valid = 1; bus_b.cfg_pattern = 8'hFF;
    bus_b.cfg_overlap = 1; bus_b.cfg_target = 2'd0;
    @(posedge clk); #1;
    bus_b.cfg_pattern = 8'h00; bus_b.cfg_target = 2'd1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      vectors++;
      if (bus_b.in_ready !== (cyc % 8 == 0) || bus_b.cfg_ready !== 0) begin
        miscompares++;
        $display("FAIL sat_ready cyc %0d: in_ready=%b cfg_ready=%b expected %b 0",
                 cyc, bus_b.in_ready, bus_b.cfg_ready, cyc % 8 == 0);
      end
      bus_b.in_valid = 1; bus_b.in_data = 8'hFF;
      @(posedge clk); #1;
      exp_cnt = (cyc < 8) ? 0 : ((cyc - 7 > 3) ? 3 : cyc - 7);
      vectors++;
      if (bus_b.hit !== (cyc >= 8) || bus_b.hit_count !== 2'(exp_cnt) ||
          bus_b.busy !== 1 || bus_b.done !== 0) begin
        miscompares++;
        $display("FAIL sat_out cyc %0d: hit=%b count=%0d busy=%b done=%b expected %b %0d 1 0",
                 cyc, bus_b.hit, bus_b.hit_count, bus_b.busy, bus_b.done, cyc >= 8, exp_cnt);
      end
    end
    bus_b.cfg_valid = 0;
    bus_b.in_valid = 0;
    bus_b.abort = 1;
    @(posedge clk); #1;
    bus_b.abort = 0;
    vectors++;
    if (bus_b.cfg_ready !== 1 || bus_b.hit_count !== 2'd3) begin
      miscompares++;
      $display("FAIL sat_abort: cfg_ready=%b count=%0d expected 1 3", bus_b.cfg_ready, bus_b.hit_count);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk); #1;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_target();
    test_back_to_back();
    test_drain();
    test_abort_match();
    test_random();
    test_saturate();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
